dmem_lsu: RTL and testbench

Load/store unit sitting directly upstream of the byte-lane data memory `dmem`. It takes one CPU memory request at a time and does the following:
- issues the request to `dmem` with the correct `we` size code;
- places store data on the byte lane(s) selected by the low address bits;
- waits the fixed memory read latency;
- returns a single-cycle response with load data extracted from the addressed lane(s), sign- or zero-extended.

Misaligned requests are flagged instead of issued.

---
 rtl/dmem_lsu.sv | 162 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the byte-lane data memory: issues one request at a time and returns a one-cycle response.
// Optional misalignment/reserved-size detection is enabled by defining DMEM_LSU_ALIGN_CHECK_EN.
module dmem_lsu #(
  parameter  int RD_LAT   = 3,
  localparam int REG_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [REG_SIZE-1:0] req_addr,
  input  logic [REG_SIZE-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [REG_SIZE-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic [REG_SIZE-1:0] daddr,
  output logic [1:0]          we,
  output logic [REG_SIZE-1:0] indata,
  input  logic [REG_SIZE-1:0] outdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic                signed_q;
  logic                wr_q;
  logic                err_q;

  logic                accept;
  logic [1:0]          eff_size;
  logic [1:0]          eff_off;
  logic                misaligned;
  logic [REG_SIZE-1:0] wdata_lanes;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [REG_SIZE-1:0] load_ext;

  assign req_ready = rst_n && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Request decode: effective size, lane offset and alignment error.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff_size   = req_size;
    eff_off    = req_addr[1:0];
    misaligned = 1'b0;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
`else
    if (req_size == 2'd3) eff_size = 2'd2;
    if (eff_size == 2'd1)      eff_off[0] = 1'b0;
    else if (eff_size == 2'd2) eff_off    = 2'd0;
`endif
  end

  always_comb begin
    case (eff_size)
      2'd0:    wdata_lanes = {4{req_wdata[7:0]}};
      2'd1:    wdata_lanes = {2{req_wdata[15:0]}};
      default: wdata_lanes = req_wdata;
    endcase
  end

  always_comb begin
    lane_b = outdata[{off_q, 3'b000} +: 8];
    lane_h = outdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
      2'd1:    load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_ext = outdata;
    endcase
  end

  // An error request still spends the issue slot (with we held at 0), so its response appears after e1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = err_q ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == LAST_WAIT) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      daddr     <= '0;
      we        <= 2'd0;
      indata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      cnt_q     <= 3'd0;
      size_q    <= 2'd0;
      off_q     <= 2'd0;
      signed_q  <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            size_q   <= eff_size;
            off_q    <= eff_off;
            signed_q <= req_signed;
            wr_q     <= req_wr;
            err_q    <= misaligned;
            if (!misaligned) begin
              daddr  <= {req_addr[REG_SIZE-1:2], eff_off};
              indata <= wdata_lanes;
              we     <= req_wr ? eff_size + 2'd1 : 2'd0;
            end
          end
        end
        S_ISSUE: begin
          we    <= 2'd0;
          cnt_q <= 3'd0;
          if (err_q) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAST_WAIT) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wr_q ? '0 : load_ext;
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed table, multi-cycle corner sequences and random traffic
// against a byte-array reference model. Expectations follow DMEM_LSU_ALIGN_CHECK_EN when defined.
module tb_dmem_lsu;

  localparam int RD_LAT = 3;
  localparam int P      = RD_LAT + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, daddr, indata, outdata;
  logic [1:0]  we;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .daddr(daddr), .we(we), .indata(indata), .outdata(outdata)
  );

  // Byte-lane memory with a fixed read latency, standing in for dmem.
  logic        mem_clr;
  logic [31:0] mem_w [0:255];
  logic [31:0] pipe  [0:RD_LAT-1];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_w[i] <= 32'd0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= 32'd0;
    end else begin
      pipe[0] <= mem_w[daddr[9:2]];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      case (we)
        2'd1: mem_w[daddr[9:2]][{daddr[1:0], 3'b000} +: 8]  <= indata[{daddr[1:0], 3'b000} +: 8];
        2'd2: mem_w[daddr[9:2]][{daddr[1], 4'b0000} +: 16] <= indata[{daddr[1], 4'b0000} +: 16];
        2'd3: mem_w[daddr[9:2]] <= indata;
        default: ;
      endcase
    end
  end
  assign outdata = pipe[RD_LAT-1];

  // Reference model: a flat byte array and the access rules in plain arithmetic.
  logic [7:0] ref_mem [0:1023];

  task automatic ref_txn(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] exp_rdata, output logic exp_err,
                         output logic [1:0] exp_we, output int exp_lat);
    int nbytes;
    int base;
    logic [31:0] v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_err = 1'b0;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    if (size == 2'd3 || (int'(addr[9:0]) % nbytes) != 0) exp_err = 1'b1;
    base = int'(addr[9:0]);
`else
    base = int'(addr[9:0]) - (int'(addr[9:0]) % nbytes);
`endif
    exp_rdata = 32'd0;
    if (!exp_err) begin
      if (wr) begin
        for (int i = 0; i < nbytes; i++) ref_mem[base + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
        exp_rdata = v;
      end
    end
    exp_we  = (exp_err || !wr) ? 2'd0 : (nbytes == 4) ? 2'd3 : 2'(nbytes);
    exp_lat = exp_err ? 1 : RD_LAT + 1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // One transaction: lat is the index k of the negedge following edge e_k where rsp_valid is seen.
  task automatic run_req(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int we_cycles, output logic [1:0] we_seen, output logic [31:0] ind_seen);
    int n;
    rdata = 32'hxxxxxxxx; err = 1'bx; lat = -1;
    we_cycles = 0; we_seen = 2'd0; ind_seen = 32'd0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (we != 2'd0) begin we_cycles++; we_seen = we; ind_seen = indata; end
      if (rsp_valid) begin rdata = rsp_rdata; err = rsp_err; lat = k; break; end
    end
    @(negedge clk);
    check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_we;
    logic [31:0] exp_ind;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, e_rd, ind;
    logic        er, e_er;
    logic [1:0]  ws, e_we;
    int          lat, e_lat, wc, pulses, ready_bad, ready_cnt, last_pulse, gap_bad, quiet;

    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;

    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_outputs", {daddr ^ indata ^ rsp_rdata, 26'd0, we, rsp_valid, rsp_err, 2'd0},
          32'd0);
    check("reset_daddr", daddr, 32'd0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Directed vectors from the test plan.
    //        wr    size  sgn   addr    wdata         rdata         err   we    indata
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2'd3, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF5A, 32'h0,        1'b0, 2'd1, 32'h5A5A5A5A});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h0000005A, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h000000EF, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h000000BE, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'h000000AD, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h00005AAD, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h000000BE, 1'b0, 2'd0, 32'h0});
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h11, 32'h0000C0DE, 32'h0,        1'b1, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h5AADBEEF, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 2'd0, 32'h0});
`else
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h11, 32'h0000C0DE, 32'h0,        1'b0, 2'd2, 32'hC0DEC0DE});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0,        1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h5AADC0DE, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h5AADC0DE, 1'b0, 2'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'hFFFFC0DE, 1'b0, 2'd0, 32'h0});
`endif

    foreach (vecs[i]) begin
      run_req(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rd, er, lat, wc, ws, ind);
      ref_txn(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, e_rd, e_er, e_we, e_lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'(RD_LAT + 1));
      check($sformatf("vec%0d_we_cycles", i), 32'(wc), (vecs[i].exp_we != 2'd0) ? 32'd1 : 32'd0);
      if (vecs[i].exp_we != 2'd0) begin
        check($sformatf("vec%0d_we", i), 32'(ws), 32'(vecs[i].exp_we));
        check($sformatf("vec%0d_indata", i), ind, vecs[i].exp_ind);
      end
    end

    // Three loads with req_valid held high: one pulse every P cycles, ready only in the IDLE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    pulses = 0; ready_bad = 0; ready_cnt = 0; last_pulse = -1; gap_bad = 0;
    @(posedge clk);
    for (int k = 0; k < 4 * P && pulses < 3; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ready_cnt++;
        if ((k % P) != RD_LAT + 2) ready_bad++;
      end
      if (rsp_valid) begin
        if (last_pulse >= 0 && k - last_pulse != P) gap_bad++;
        last_pulse = k;
        pulses++;
        if (pulses == 3) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_pulse_gap", 32'(gap_bad), 32'd0);
    check("b2b_ready_busy", 32'(ready_bad), 32'd0);
    check("b2b_ready_idle", 32'(ready_cnt), 32'd2);
    repeat (2) @(negedge clk);

    // Reset asserted during WAIT of a load: outputs clear at once and the response is dropped.
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_daddr", daddr, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async_daddr", daddr, 32'd0);
    check("async_indata", indata, 32'd0);
    check("async_we", 32'(we), 32'd0);
    check("async_rsp", {30'd0, rsp_valid, rsp_err} | rsp_rdata, 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) quiet++;
    end
    check("no_rsp_after_reset", 32'(quiet), 32'd0);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, wc, ws, ind);
    ref_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_rd, e_er, e_we, e_lat);
    check("post_reset_rdata", rd, e_rd);
    check("post_reset_latency", 32'(lat), 32'(e_lat));

    // Random traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic        r_wr, r_sgn;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata;
      r_wr = 1'($urandom); r_sgn = 1'($urandom); r_size = 2'($urandom);
      r_addr = 32'($urandom_range(0, 1023)); r_wdata = $urandom;
      run_req(r_wr, r_size, r_sgn, r_addr, r_wdata, rd, er, lat, wc, ws, ind);
      ref_txn(r_wr, r_size, r_sgn, r_addr, r_wdata, e_rd, e_er, e_we, e_lat);
      check($sformatf("rnd%0d_rdata", t), rd, e_rd);
      check($sformatf("rnd%0d_err", t), 32'(er), 32'(e_er));
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(e_lat));
      check($sformatf("rnd%0d_we", t), {wc[29:0], ws}, (e_we != 2'd0) ? {30'd1, e_we} : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
